// File: rtl/hq2x_sched.sv
// Timing sequencer for the Hq2x 2x scaler: turns source pixel timing into
// 4-cycle input bursts plus output-side line doubling control.
module hq2x_sched #(
  parameter int unsigned HW = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       hblank_in,
  input  logic       vblank_in,
  output logic       ce_in,
  output logic       reset_line,
  output logic       reset_frame,
  output logic       ce_out,
  output logic [1:0] read_y,
  output logic       hblank_out,
  output logic       vblank_out,
  output logic       spacing_err
);

  localparam int unsigned OW = HW + 2;
  localparam logic [HW-1:0] HMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_e;

  state_e         state_q;
  logic           ce_q;
  logic           serr_q;

  logic           rl_q, rl_d;
  logic           rf_q, rf_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [HW-1:0]  acnt_q, acnt_d;
  logic [HW-1:0]  htot_q, htot_d;
  logic [HW-1:0]  hact_q, hact_d;
  logic           bank_q, bank_d;
  logic           ry1_q, ry1_d;
  logic           vb_q, vb_d;

  logic [OW-1:0]  ocnt_q, ocnt_d;
  logic           ry0_q, ry0_d;
  logic           hb_q, hb_d;

  logic           accept;
  logic           early;
  logic           line_start;
  logic [HW-1:0]  hcnt_inc;
  logic [HW-1:0]  acnt_inc;
  logic [OW-1:0]  two_tot;
  logic [OW-1:0]  two_act;
  logic [OW-1:0]  ocnt_inc;

  // A pixel is taken when idle or in the last burst beat (back-to-back bursts)
  assign accept     = ce_pix && ((state_q == S_IDLE) || (state_q == S_B3));
  assign early      = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign line_start = accept && !hblank_in && rl_q;

  assign hcnt_inc = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + HW'(1);
  assign acnt_inc = (acnt_q == HMAX) ? acnt_q : acnt_q + HW'(1);
  assign two_tot  = {1'b0, htot_q, 1'b0};
  assign two_act  = {1'b0, hact_q, 1'b0};
  assign ocnt_inc = ocnt_q + OW'(1);

  // Burst FSM: four ce_in beats per accepted pixel, sticky spacing error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ce_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      if (ce_pix && early) serr_q <= 1'b1;
      if (accept) begin
        state_q <= S_B0;
        ce_q    <= 1'b1;
      end else begin
        case (state_q)
          S_B0:    begin state_q <= S_B1;   ce_q <= 1'b1; end
          S_B1:    begin state_q <= S_B2;   ce_q <= 1'b1; end
          S_B2:    begin state_q <= S_B3;   ce_q <= 1'b1; end
          default: begin state_q <= S_IDLE; ce_q <= 1'b0; end
        endcase
      end
    end
  end

  // Input capture, line measurement and bank selection
  always_comb begin
    rl_d   = rl_q;
    rf_d   = rf_q;
    hcnt_d = hcnt_q;
    acnt_d = acnt_q;
    htot_d = htot_q;
    hact_d = hact_q;
    bank_d = bank_q;
    ry1_d  = ry1_q;
    vb_d   = vb_q;
    if (accept) begin
      rl_d = hblank_in;
      rf_d = vblank_in;
      if (line_start) begin
        htot_d = hcnt_q;
        hact_d = acnt_q;
        hcnt_d = HW'(1);
        acnt_d = HW'(1);
        bank_d = rf_q ? 1'b0 : ~bank_q;
        ry1_d  = ~bank_d;
        vb_d   = rf_q;
      end else begin
        hcnt_d = hcnt_inc;
        if (!hblank_in) acnt_d = acnt_inc;
      end
    end
  end

  // Output side: two halves of 2*H_TOT pulses, then hold until next line
  always_comb begin
    ocnt_d = ocnt_q;
    ry0_d  = ry0_q;
    hb_d   = hb_q;
    if (line_start) begin
      ocnt_d = '0;
      ry0_d  = 1'b0;
      hb_d   = (hcnt_q == '0) || (acnt_q == '0);
    end else if (ce_q) begin
      if (ocnt_inc >= two_tot) begin
        if (!ry0_q) begin
          ocnt_d = '0;
          ry0_d  = 1'b1;
        end else begin
          ocnt_d = two_tot;
        end
      end else begin
        ocnt_d = ocnt_inc;
      end
      hb_d = (ocnt_d >= two_act) || (htot_q == '0);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rl_q   <= 1'b0;
      rf_q   <= 1'b0;
      hcnt_q <= '0;
      acnt_q <= '0;
      htot_q <= '0;
      hact_q <= '0;
      bank_q <= 1'b0;
      ry1_q  <= 1'b0;
      vb_q   <= 1'b1;
      ocnt_q <= '0;
      ry0_q  <= 1'b0;
      hb_q   <= 1'b1;
    end else begin
      rl_q   <= rl_d;
      rf_q   <= rf_d;
      hcnt_q <= hcnt_d;
      acnt_q <= acnt_d;
      htot_q <= htot_d;
      hact_q <= hact_d;
      bank_q <= bank_d;
      ry1_q  <= ry1_d;
      vb_q   <= vb_d;
      ocnt_q <= ocnt_d;
      ry0_q  <= ry0_d;
      hb_q   <= hb_d;
    end
  end

  assign ce_in       = ce_q;
  assign ce_out      = ce_q;
  assign reset_line  = rl_q;
  assign reset_frame = rf_q;
  assign read_y      = {ry1_q, ry0_q};
  assign hblank_out  = hb_q;
  assign vblank_out  = vb_q;
  assign spacing_err = serr_q;

endmodule

// File: tb/tb_hq2x_sched.sv
// Directed bench for hq2x_sched: burst timing, spacing error, line doubling,
// bank/vblank sequencing and asynchronous reset mid-burst.
module tb_hq2x_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic       hblank_in;
  logic       vblank_in;
  logic       ce_in;
  logic       reset_line;
  logic       reset_frame;
  logic       ce_out;
  logic [1:0] read_y;
  logic       hblank_out;
  logic       vblank_out;
  logic       spacing_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  bit [3:0] pq[$];

  hq2x_sched #(.HW(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .hblank_in   (hblank_in),
    .vblank_in   (vblank_in),
    .ce_in       (ce_in),
    .reset_line  (reset_line),
    .reset_frame (reset_frame),
    .ce_out      (ce_out),
    .read_y      (read_y),
    .hblank_out  (hblank_out),
    .vblank_out  (vblank_out),
    .spacing_err (spacing_err)
  );

  always #5 clk = ~clk;

  // Record {read_y, hblank_out, vblank_out} at every ce_out pulse
  always @(negedge clk) begin
    if (ce_out) pq.push_back({read_y, hblank_out, vblank_out});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One source pixel, 5 clocks spacing; called and returns at a negedge
  task automatic pix(input logic h, input logic v);
    ce_pix    = 1'b1;
    hblank_in = h;
    vblank_in = v;
    @(negedge clk);
    ce_pix = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One source line: 6 active pixels then 4 blank
  task automatic src_line(input logic v);
    for (int i = 0; i < 6; i++) pix(1'b0, v);
    for (int i = 0; i < 4; i++) pix(1'b1, v);
  endtask

  // Summarise recorded pulses against the 10/6 line shape
  task automatic analyze(output int n, output int hb_lo, output int ry0_lo,
                         output int pat_err, output int ry1_hi, output int vb_hi);
    n = pq.size(); hb_lo = 0; ry0_lo = 0; pat_err = 0; ry1_hi = 0; vb_hi = 0;
    for (int k = 0; k < pq.size(); k++) begin
      bit [3:0] s;
      s = pq[k];
      if (!s[1]) hb_lo++;
      if (!s[2]) ry0_lo++;
      if (s[3])  ry1_hi++;
      if (s[0])  vb_hi++;
      if ((s[2] != (k >= 20)) || (s[1] != ((k % 20) >= 12))) pat_err++;
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] pat_o;
    logic [9:0] pat10;
    int n, hb_lo, ry0_lo, pat_err, ry1_hi, vb_hi;
    int exp_ry1 [2:7];
    int exp_vb  [2:7];

    reset_n = 1'b0; ce_pix = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ce_in", ce_in, 0);
    check("rst_ce_out", ce_out, 0);
    check("rst_read_y", read_y, 0);
    check("rst_hblank_out", hblank_out, 1);
    check("rst_vblank_out", vblank_out, 1);
    check("rst_reset_line", reset_line, 0);
    check("rst_spacing_err", spacing_err, 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single pixel: four beats exactly
    ce_pix = 1'b1; hblank_in = 1'b1; vblank_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ce_pix = 1'b0;
      pat[i] = ce_in;
      pat_o[i] = ce_out;
      if (i == 1) begin
        check("cap_reset_line", reset_line, 1);
        check("cap_reset_frame", reset_frame, 0);
      end
    end
    check("single_ce_in", pat, 8'h0F);
    check("single_ce_out", pat_o, 8'h0F);
    check("no_spacing_err", spacing_err, 0);

    // Pulse two cycles later is ignored and flags an error
    ce_pix = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ce_pix = 1'b0;
      if (i == 1) ce_pix = 1'b1;
      if (i == 2) ce_pix = 1'b0;
      pat[i] = ce_in;
    end
    check("close_ce_in", pat, 8'h0F);
    check("spacing_err_set", spacing_err, 1);
    repeat (10) @(negedge clk);
    check("spacing_err_sticky", spacing_err, 1);

    // Pulse in the last beat chains a second burst
    ce_pix = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) ce_pix = 1'b0;
      if (i == 3) ce_pix = 1'b1;
      if (i == 4) ce_pix = 1'b0;
      pat10[i] = ce_in;
    end
    check("b2b_ce_in", pat10, 10'h0FF);

    // Fresh start for the line tests
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1);

    // First line: H_TOT=4 from the leading blanks, H_ACT=0
    pq.delete();
    src_line(1'b1);
    analyze(n, hb_lo, ry0_lo, pat_err, ry1_hi, vb_hi);
    check("l1_pulses", n, 40);
    check("l1_hb_low", hb_lo, 0);
    check("l1_ry0_low", ry0_lo, 8);
    check("l1_ry1", ry1_hi, 40);
    check("l1_vb", vb_hi, 40);

    exp_ry1 = '{40, 40, 40, 0, 40, 0};
    exp_vb  = '{40, 40, 40, 0, 0, 0};
    for (int l = 2; l <= 7; l++) begin
      pq.delete();
      src_line((l <= 3) ? 1'b1 : 1'b0);
      analyze(n, hb_lo, ry0_lo, pat_err, ry1_hi, vb_hi);
      check($sformatf("l%0d_pulses", l), n, 40);
      check($sformatf("l%0d_pattern", l), pat_err, 0);
      check($sformatf("l%0d_hb_low", l), hb_lo, 24);
      check($sformatf("l%0d_ry0_low", l), ry0_lo, 20);
      check($sformatf("l%0d_ry1", l), ry1_hi, exp_ry1[l]);
      check($sformatf("l%0d_vb", l), vb_hi, exp_vb[l]);
    end

    // Reset during beat B1 of an active pixel
    ce_pix = 1'b1; hblank_in = 1'b0; vblank_in = 1'b0;
    @(negedge clk);
    ce_pix = 1'b0;
    @(negedge clk);
    check("pre_rst_ce_in", ce_in, 1);
    check("pre_rst_hblank_out", hblank_out, 0);
    check("pre_rst_vblank_out", vblank_out, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ce_in", ce_in, 0);
    check("mid_rst_hblank_out", hblank_out, 1);
    check("mid_rst_vblank_out", vblank_out, 1);
    check("mid_rst_read_y", read_y, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pq.delete();
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b0);
    src_line(1'b0);
    analyze(n, hb_lo, ry0_lo, pat_err, ry1_hi, vb_hi);
    check("post_rst_pulses", n, 56);
    check("post_rst_hb_low", hb_lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
